mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter.
- A 256-byte circular transmit buffer plus head/tail index registers, accessed over the standard cmd_start/cmd_ready/rdata_valid memory interface.
- Sits behind the memory-map controller, which forwards accesses in 0xff000000–0xff000107 with the base already subtracted.
- Software fills buffer bytes, then advances the tail; hardware serialises bytes from head up to tail-1 as 8N1 and advances head.

---
 rtl/mmio_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with 256-byte circular buffer
module mmio_uart_tx #(
  parameter int CLK_FREQ     = 27000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        uart_tx,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
  input  logic [31:0] input_wdata
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Buffer RAM: 64 little-endian words, byte n lives in word n/4
  logic [31:0]   mem_q [64];

  logic          cmd_ready_q;
  logic          rdata_valid_q;
  logic [31:0]   rdata_q;
  logic [7:0]    tail_q;
  logic [7:0]    head_q;

  state_e        state_q;
  logic          tx_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;

  logic          accept;
  logic          sel_buf;
  logic          sel_tail;
  logic          sel_head;
  logic [31:0]   rdata_d;
  logic [31:0]   head_word;
  logic [7:0]    tx_byte_d;

  // Low address bits select a byte within a word and carry no meaning on the bus
  logic          unused_addr_bits;
  assign unused_addr_bits = ^input_addr[1:0];

  assign accept   = input_cmd_start & cmd_ready_q;
  assign sel_buf  = (input_addr[31:8] == 24'd0);
  assign sel_tail = (input_addr[31:2] == 30'h40);
  assign sel_head = (input_addr[31:2] == 30'h41);

  assign output_cmd_ready   = cmd_ready_q;
  assign output_rdata_valid = rdata_valid_q;
  assign output_rdata       = rdata_q;
  assign uart_tx            = tx_q;

  // Read-data mux; HEAD is sampled before any same-edge increment
  always_comb begin
    rdata_d = 32'd0;
    if (sel_buf) begin
      rdata_d = mem_q[input_addr[7:2]];
    end else if (sel_tail) begin
      rdata_d = {24'd0, tail_q};
    end else if (sel_head) begin
      rdata_d = {24'd0, head_q};
    end
  end

  // Pick the byte at head out of its word for the transmitter latch
  always_comb begin
    head_word = mem_q[head_q[7:2]];
    tx_byte_d = head_word[7:0];
    case (head_q[1:0])
      2'd0: tx_byte_d = head_word[7:0];
      2'd1: tx_byte_d = head_word[15:8];
      2'd2: tx_byte_d = head_word[23:16];
      2'd3: tx_byte_d = head_word[31:24];
      default: tx_byte_d = head_word[7:0];
    endcase
  end

  // Buffer writes; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (accept && input_cmd_write && sel_buf) begin
      mem_q[input_addr[7:2]] <= input_wdata;
    end
  end

  // Bus handshake: writes complete at the accept edge, reads return one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q   <= 1'b1;
      rdata_valid_q <= 1'b0;
      rdata_q       <= 32'd0;
      tail_q        <= 8'd0;
    end else begin
      rdata_valid_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      if (accept) begin
        if (input_cmd_write) begin
          if (sel_tail) begin
            tail_q <= input_wdata[7:0];
          end
        end else begin
          rdata_q       <= rdata_d;
          rdata_valid_q <= 1'b1;
          cmd_ready_q   <= 1'b0;
        end
      end
    end
  end

  // Transmit FSM: latch byte[head] and bump head together, then shift out 8N1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      head_q    <= 8'd0;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (head_q != tail_q) begin
            shift_q <= tx_byte_d;
            head_q  <= head_q + 8'd1;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_tx;
  logic        cmd_start;
  logic        cmd_write;
  logic        cmd_ready;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .uart_tx            (uart_tx),
    .input_cmd_start    (cmd_start),
    .input_cmd_write    (cmd_write),
    .output_cmd_ready   (cmd_ready),
    .input_addr         (addr),
    .output_rdata       (rdata),
    .output_rdata_valid (rdata_valid),
    .input_wdata        (wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cmd_start = 1'b1;
    cmd_write = 1'b1;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    cmd_start = 1'b1;
    cmd_write = 1'b0;
    addr      = a;
    @(negedge clk);
    cmd_start = 1'b0;
    check("rd_valid", {31'd0, rdata_valid}, 32'd1);
    check("rd_ready_low", {31'd0, cmd_ready}, 32'd0);
    d = rdata;
    @(negedge clk);
    check("rd_valid_drop", {31'd0, rdata_valid}, 32'd0);
  endtask

  // Waits for a start bit (bounded) and samples each bit mid-period (4 clocks/bit).
  // With cut set, writes TAIL=cut_val during the start bit without disturbing timing.
  task automatic expect_frame(input logic [7:0] exp, input bit cut, input logic [7:0] cut_val);
    int k;
    logic [7:0] got;
    k = 0;
    while (uart_tx !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (uart_tx !== 1'b0) begin
      check("frame_start_timeout", {31'd0, uart_tx}, 32'd0);
      return;
    end
    if (cut) begin
      cmd_start = 1'b1;
      cmd_write = 1'b1;
      addr      = 32'h100;
      wdata     = {24'd0, cut_val};
      @(negedge clk);
      cmd_start = 1'b0;
      cmd_write = 1'b0;
      @(negedge clk);
    end else begin
      repeat (2) @(negedge clk);
    end
    check("start_bit", {31'd0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      got[i] = uart_tx;
    end
    repeat (4) @(negedge clk);
    check("stop_bit", {31'd0, uart_tx}, 32'd1);
    check("frame_byte", {24'd0, got}, {24'd0, exp});
  endtask

  logic [31:0] rd;
  bit          idle_ok;
  int          k;

  initial begin
    rst_n     = 1'b0;
    cmd_start = 1'b0;
    cmd_write = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    bus_read(32'h104, rd);
    check("head_reset", rd, 32'd0);
    bus_read(32'h100, rd);
    check("tail_reset", rd, 32'd0);

    // "Hell" in word 0, then release four bytes
    bus_write(32'h000, 32'h6C6C6548);
    bus_write(32'h100, 32'd4);
    expect_frame(8'h48, 1'b0, 8'h00);
    expect_frame(8'h65, 1'b0, 8'h00);
    expect_frame(8'h6C, 1'b0, 8'h00);
    expect_frame(8'h6C, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    bus_read(32'h104, rd);
    check("head_after_hell", rd, 32'd4);

    // Readback, unmapped read, read-only HEAD
    bus_write(32'h0FC, 32'hDEADBEEF);
    bus_read(32'h0FC, rd);
    check("buf_readback", rd, 32'hDEADBEEF);
    bus_read(32'h200, rd);
    check("unmapped_read", rd, 32'd0);
    bus_write(32'h104, 32'd9);
    bus_read(32'h104, rd);
    check("head_readonly", rd, 32'd4);

    // Drain up to 0xFE (250 frames of 41 clocks), contents not checked
    bus_write(32'h100, 32'hFE);
    repeat (10400) @(negedge clk);
    bus_read(32'h104, rd);
    check("head_at_fe", rd, 32'hFE);
    check("idle_at_fe", {31'd0, uart_tx}, 32'd1);

    // Wrap across 255 -> 0
    bus_write(32'h0FC, 32'h2211BEEF);
    bus_write(32'h000, 32'h00004433);
    bus_write(32'h100, 32'h02);
    expect_frame(8'h11, 1'b0, 8'h00);
    expect_frame(8'h22, 1'b0, 8'h00);
    expect_frame(8'h33, 1'b0, 8'h00);
    expect_frame(8'h44, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    bus_read(32'h104, rd);
    check("head_after_wrap", rd, 32'h02);

    // HEAD read on the latch edge returns the pre-increment value
    bus_write(32'h000, 32'h66554433);
    cmd_start = 1'b1;
    cmd_write = 1'b1;
    addr      = 32'h100;
    wdata     = 32'd4;
    @(negedge clk);
    cmd_write = 1'b0;
    addr      = 32'h104;
    @(negedge clk);
    cmd_start = 1'b0;
    check("latch_edge_valid", {31'd0, rdata_valid}, 32'd1);
    check("latch_edge_head", rdata, 32'd2);
    expect_frame(8'h55, 1'b0, 8'h00);
    expect_frame(8'h66, 1'b0, 8'h00);

    // TAIL=HEAD mid-queue: frame in flight finishes, nothing follows
    bus_write(32'h004, 32'h88777A79);
    bus_write(32'h100, 32'd8);
    expect_frame(8'h79, 1'b1, 8'h05);
    idle_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) idle_ok = 1'b0;
    end
    check("discard_idle", {31'd0, idle_ok}, 32'd1);
    bus_read(32'h104, rd);
    check("head_after_discard", rd, 32'd5);

    // Reset during data bit 0 of 0x7A (a zero bit)
    bus_write(32'h100, 32'd6);
    k = 0;
    while (uart_tx !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("mid_frame_started", {31'd0, uart_tx}, 32'd0);
    repeat (6) @(negedge clk);
    check("data_bit0_low", {31'd0, uart_tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check("async_reset_tx", {31'd0, uart_tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(32'h104, rd);
    check("head_post_reset", rd, 32'd0);
    bus_read(32'h100, rd);
    check("tail_post_reset", rd, 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) idle_ok = 1'b0;
    end
    check("post_reset_idle", {31'd0, idle_ok}, 32'd1);

    // Buffer survives reset: byte 0 is still 0x33
    bus_write(32'h100, 32'd1);
    expect_frame(8'h33, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
